// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures as SHORT, LONG or DOUBLE and presents each
// one as a single-entry event with a valid/ready handshake and a sticky drop flag.
module key_event_decoder #(
  parameter logic        ACTIVE      = 1'b1,
  parameter int unsigned LONG_TIME   = 60000000,
  parameter int unsigned DCLICK_TIME = 18000000,
  parameter int unsigned BITS        = 26
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_i,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_ovf,
  output logic       key_pressed
);

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_DOUBLE = 2'b11;

  localparam logic [BITS-1:0] LONG_LAST   = BITS'(LONG_TIME - 32'd1);
  localparam logic [BITS-1:0] DCLICK_LAST = BITS'(DCLICK_TIME - 32'd1);
  localparam logic [BITS-1:0] CNT_ONE     = {{(BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [BITS-1:0] cnt_r, cnt_s;
  logic            prev_r;
  logic            press_s, release_s;
  logic            emit_s;
  logic [1:0]      emit_code_s;
  logic            evt_valid_s, evt_ovf_s;
  logic [1:0]      evt_code_s;

  assign press_s   = key_pressed & ~prev_r;
  assign release_s = ~key_pressed & prev_r;

  // Gesture FSM: next state, gesture counter and event emission.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    emit_s      = 1'b0;
    emit_code_s = CODE_NONE;
    case (state_r)
      ST_IDLE: begin
        if (press_s) state_s = ST_PRESS1;
        else         state_s = ST_IDLE;
      end
      ST_PRESS1: begin
        if (release_s) begin
          state_s = ST_WAIT2;
        end else if (cnt_r == LONG_LAST) begin
          emit_s      = 1'b1;
          emit_code_s = CODE_LONG;
          state_s     = ST_HELD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT2: begin
        if (press_s) begin
          state_s = ST_PRESS2;
        end else if (cnt_r == DCLICK_LAST) begin
          emit_s      = 1'b1;
          emit_code_s = CODE_SHORT;
          state_s     = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PRESS2: begin
        // Second press length is irrelevant: only its release matters.
        if (release_s) begin
          emit_s      = 1'b1;
          emit_code_s = CODE_DOUBLE;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_PRESS2;
        end
      end
      ST_HELD: begin
        if (release_s) state_s = ST_IDLE;
        else           state_s = ST_HELD;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (state_s != state_r) cnt_s = '0;
    else                    cnt_s = cnt_s;
  end

  // Single-entry event slot: load, accept, or drop-and-flag when stalled.
  always_comb begin
    evt_valid_s = evt_valid;
    evt_code_s  = evt_code;
    evt_ovf_s   = evt_ovf;
    if (emit_s && (!evt_valid || evt_ready)) begin
      evt_valid_s = 1'b1;
      evt_code_s  = emit_code_s;
    end else if (emit_s) begin
      evt_ovf_s = 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid_s = 1'b0;
      evt_code_s  = CODE_NONE;
    end else begin
      evt_valid_s = evt_valid;
    end
  end

  // State, counter, input sampling and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      prev_r      <= 1'b0;
      key_pressed <= 1'b0;
      evt_valid   <= 1'b0;
      evt_code    <= CODE_NONE;
      evt_ovf     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      prev_r      <= key_pressed;
      key_pressed <= (key_i == ACTIVE);
      evt_valid   <= evt_valid_s;
      evt_code    <= evt_code_s;
      evt_ovf     <= evt_ovf_s;
    end
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced key level produced by the key debouncer and classifies each gesture as a short press, long press, or double click.
- Each classified gesture is presented as a one-entry event with a valid/ready handshake to the control logic.
- Sits between the debouncer output and the system FSM, one instance per key.

Parameters:
ACTIVE, 1, input level meaning "pressed" (1 = active-high key, 0 = active-low key)
LONG_TIME, 60000000, cycles a press must be held to count as a long press (1 s at 60 MHz); must be at least 2
DCLICK_TIME, 18000000, cycles after release within which a second press makes a double click (0.3 s at 60 MHz); must be at least 2
BITS, 26, counter width; must satisfy 2^BITS > max(LONG_TIME, DCLICK_TIME)

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge
sys_rst  input  1  synchronous reset, active-high
key_i  input  1  debounced key level, already synchronous to sys_clk
evt_ready  input  1  consumer accepts the pending event
evt_valid  output  1  event pending
evt_code  output  2  event code: 01 = SHORT, 10 = LONG, 11 = DOUBLE; 00 whenever evt_valid = 0
evt_ovf  output  1  sticky flag: an event was dropped
key_pressed  output  1  registered, polarity-normalised key level (1 = pressed)

Behaviour:
- Reset (sys_rst = 1 at a clock edge) clears all state:
  - evt_valid = 0, evt_code = 00, evt_ovf = 0, key_pressed = 0.
  - FSM = IDLE, cnt = 0.
  - Reset has priority over every other event, including mid-gesture and with an event pending; in-flight gestures are discarded.
- Input sampling:
  - key_pressed <= (key_i == ACTIVE).
  - press = key_pressed & ~prev; release = ~key_pressed & prev; prev is the previous key_pressed and resets to 0.
  - A key already held when reset deasserts therefore registers as a press two cycles later.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, HELD. cnt is a BITS-wide up-counter, cleared on every state change.
  - IDLE: press -> PRESS1.
  - PRESS1:
    - release -> WAIT2.
    - Else if cnt == LONG_TIME-1, emit LONG -> HELD.
    - Else cnt++.
  - WAIT2:
    - press -> PRESS2.
    - Else if cnt == DCLICK_TIME-1, emit SHORT -> IDLE.
    - Else cnt++.
  - PRESS2: release -> emit DOUBLE -> IDLE. Hold duration is ignored; no LONG is ever emitted from PRESS2.
  - HELD: release -> IDLE. No further events until release.
- Event timing and latency:
  - evt_valid and evt_code update on the same edge as the emitting FSM transition.
  - SHORT appears DCLICK_TIME cycles after the cycle release is seen.
  - LONG appears LONG_TIME cycles after the cycle press is seen.
- Handshake:
  - A transfer occurs on any edge where evt_valid & evt_ready.
  - evt_valid is cleared next cycle unless a new event is emitted on that same edge. In that case the new code loads and evt_valid stays 1 (back-to-back, no bubble).
  - evt_ready while evt_valid = 0 has no effect.
  - evt_code is held stable while evt_valid & ~evt_ready.
- Overflow:
  - An event emitted while evt_valid & ~evt_ready is dropped; the pending event is kept and evt_ovf <= 1.
  - evt_ovf clears only on reset.
  - The FSM still advances normally when an event is dropped.
- Counter: never wraps; it is bounded by the compare values. Width violations of BITS are a configuration error and are not checked in RTL.

Test Plan:
(All scenarios use ACTIVE = 1, LONG_TIME = 20, DCLICK_TIME = 8, evt_ready = 1 unless stated.)
1. Short press: key_i high 5 cycles, then low -> exactly one SHORT (evt_code = 01) for one cycle, 8 cycles after release is seen; evt_ovf stays 0.
2. Long press: key_i high 40 cycles -> LONG (10) 20 cycles after press is seen. No event on the later release, and no SHORT afterwards.
3. Double click: high 3, low 4, high 3, low -> one DOUBLE (11) on the cycle the second release is seen; no SHORT emitted. Repeating with a 9-cycle gap instead gives SHORT, SHORT.
4. Backpressure and overflow: evt_ready = 0, two short presses 30 cycles apart -> evt_valid stays 1 with code 01 held, evt_ovf = 1 after the second press. Raising evt_ready for one cycle then gives evt_valid = 0.
5. Simultaneous accept and emit: a SHORT pending, evt_ready = 1 on the exact edge a LONG is emitted -> evt_valid remains 1 and evt_code becomes 10 with no gap cycle.
6. Reset mid-gesture: key held 10 cycles, pulse sys_rst for 1 cycle while still held -> all outputs 0. The held key is re-detected as a press, and LONG fires 20 cycles after it is seen (not earlier). ACTIVE = 0 variant: inverted stimulus gives identical events.
